// File: rtl/work_dispatcher.sv
// Frame dispatcher for the Julia worker array: issues raster pixels to idle workers
// and round-robin arbitrates their finished results onto a single memory write port.
module work_dispatcher #(
    parameter int NUM_WORKERS = 4,
    parameter int WIDTH       = 640,
    parameter int HEIGHT      = 480,
    parameter int XW          = 10,
    parameter int YW          = 9,
    localparam int IW         = (NUM_WORKERS > 1) ? $clog2(NUM_WORKERS) : 1
) (
    input  logic                   clk,
    input  logic                   n_rst,
    input  logic                   frame_start,
    input  logic [NUM_WORKERS-1:0] JW_ready,
    input  logic [NUM_WORKERS-1:0] JW_done,
    input  logic                   mc_ack,
    output logic [NUM_WORKERS-1:0] JW_start,
    output logic [XW-1:0]          pix_x,
    output logic [YW-1:0]          pix_y,
    output logic [NUM_WORKERS-1:0] MC_busy,
    output logic                   mc_req,
    output logic [IW-1:0]          mc_sel,
    output logic [XW-1:0]          mc_x,
    output logic [YW-1:0]          mc_y,
    output logic                   busy,
    output logic                   frame_done
);

    typedef enum logic [1:0] {IDLE, DISPATCH, DRAIN, DONE} main_state_t;
    typedef enum logic [1:0] {W_ARB, W_REQ, W_REL} wr_state_t;

    main_state_t state, state_n;
    wr_state_t   wstate, wstate_n;

    logic [NUM_WORKERS-1:0] active, active_n;
    logic [XW-1:0]          x, x_n;
    logic [YW-1:0]          y, y_n;
    logic [IW-1:0]          rr, rr_n;

    logic [NUM_WORKERS-1:0] jw_start_n, mc_busy_n;
    logic [XW-1:0]          pix_x_n, mc_x_n;
    logic [YW-1:0]          pix_y_n, mc_y_n;
    logic                   mc_req_n, busy_n, frame_done_n;
    logic [IW-1:0]          mc_sel_n;

    logic [XW-1:0] coord_x [NUM_WORKERS];
    logic [YW-1:0] coord_y [NUM_WORKERS];

    logic [NUM_WORKERS-1:0] eligible, cand, set_mask, clr_mask;
    logic                   issue_found, grant_found, coord_we;
    logic [IW-1:0]          issue_idx, grant_idx, scan_idx;
    int                     scan_sum;

    always_comb begin
        // NOTE: every variable gets a default before any branch, so no path leaves one
        // unassigned and no latch is inferred.
        state_n      = state;
        wstate_n     = wstate;
        x_n          = x;
        y_n          = y;
        rr_n         = rr;
        jw_start_n   = '0;
        pix_x_n      = pix_x;
        pix_y_n      = pix_y;
        mc_busy_n    = MC_busy;
        mc_req_n     = mc_req;
        mc_sel_n     = mc_sel;
        mc_x_n       = mc_x;
        mc_y_n       = mc_y;
        frame_done_n = 1'b0;
        set_mask     = '0;
        clr_mask     = '0;
        coord_we     = 1'b0;
        issue_found  = 1'b0;
        issue_idx    = '0;
        grant_found  = 1'b0;
        grant_idx    = rr;
        scan_sum     = 0;
        scan_idx     = '0;

        // A worker stays ineligible from issue until its release has cleared active.
        eligible = JW_ready & ~active;
        cand     = JW_done & active;

        for (int i = NUM_WORKERS - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                issue_found = 1'b1;
                issue_idx   = IW'(i);
            end
        end

        for (int k = 0; k < NUM_WORKERS; k++) begin
            scan_sum = int'(rr) + k;
            if (scan_sum >= NUM_WORKERS) scan_sum = scan_sum - NUM_WORKERS;
            scan_idx = IW'(scan_sum);
            if (!grant_found && cand[scan_idx]) begin
                grant_found = 1'b1;
                grant_idx   = scan_idx;
            end
        end

        case (state)
            IDLE: begin
                if (frame_start) begin
                    state_n = DISPATCH;
                    x_n     = '0;
                    y_n     = '0;
                end
            end
            DISPATCH: begin
                if (issue_found) begin
                    jw_start_n[issue_idx] = 1'b1;
                    set_mask[issue_idx]   = 1'b1;
                    pix_x_n  = x;
                    pix_y_n  = y;
                    coord_we = 1'b1;
                    if (x == XW'(WIDTH - 1)) begin
                        if (y == YW'(HEIGHT - 1)) begin
                            state_n = DRAIN;
                        end else begin
                            x_n = '0;
                            y_n = y + 1'b1;
                        end
                    end else begin
                        x_n = x + 1'b1;
                    end
                end
            end
            DRAIN: begin
                if (active == '0 && wstate == W_ARB) begin
                    state_n      = DONE;
                    frame_done_n = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase

        case (wstate)
            W_ARB: begin
                if (grant_found) begin
                    wstate_n = W_REQ;
                    mc_req_n = 1'b1;
                    mc_sel_n = grant_idx;
                    mc_x_n   = coord_x[grant_idx];
                    mc_y_n   = coord_y[grant_idx];
                end
            end
            W_REQ: begin
                if (mc_ack) begin
                    wstate_n          = W_REL;
                    mc_req_n          = 1'b0;
                    mc_busy_n[mc_sel] = 1'b0;
                end
            end
            W_REL: begin
                wstate_n         = W_ARB;
                mc_busy_n        = '1;
                clr_mask[mc_sel] = 1'b1;
                rr_n = (mc_sel == IW'(NUM_WORKERS - 1)) ? '0 : mc_sel + 1'b1;
            end
            default: wstate_n = W_ARB;
        endcase

        active_n = (active | set_mask) & ~clr_mask;
        busy_n   = (state_n != IDLE);
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // updates from the values present before the edge.
        if (!n_rst) begin
            state      <= IDLE;
            wstate     <= W_ARB;
            active     <= '0;
            x          <= '0;
            y          <= '0;
            rr         <= '0;
            JW_start   <= '0;
            pix_x      <= '0;
            pix_y      <= '0;
            MC_busy    <= '1;
            mc_req     <= 1'b0;
            mc_sel     <= '0;
            mc_x       <= '0;
            mc_y       <= '0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_n;
            wstate     <= wstate_n;
            active     <= active_n;
            x          <= x_n;
            y          <= y_n;
            rr         <= rr_n;
            JW_start   <= jw_start_n;
            pix_x      <= pix_x_n;
            pix_y      <= pix_y_n;
            MC_busy    <= mc_busy_n;
            mc_req     <= mc_req_n;
            mc_sel     <= mc_sel_n;
            mc_x       <= mc_x_n;
            mc_y       <= mc_y_n;
            busy       <= busy_n;
            frame_done <= frame_done_n;
        end
    end

    // NOTE: the coordinate store has no reset; an entry is only read once its
    // active bit is set, which happens on the same edge that writes it.
    always_ff @(posedge clk) begin
        if (coord_we) begin
            coord_x[issue_idx] <= x;
            coord_y[issue_idx] <= y;
        end
    end

endmodule

// File: tb/tb_work_dispatcher.sv
// Self-checking bench for work_dispatcher on a 4x2 frame with four workers:
// directed vector table plus hand-written raster, round-robin and ack-stall sequences.
module tb_work_dispatcher;

    localparam int NW = 4;
    localparam int W  = 4;
    localparam int H  = 2;
    localparam int XW = 3;
    localparam int YW = 2;
    localparam int IW = 2;

    logic          clk = 1'b0;
    logic          n_rst = 1'b0;
    logic          frame_start = 1'b0;
    logic          mc_ack = 1'b0;
    logic [NW-1:0] JW_ready = '0;
    logic [NW-1:0] JW_done = '0;
    logic [NW-1:0] JW_start, MC_busy;
    logic [XW-1:0] pix_x, mc_x;
    logic [YW-1:0] pix_y, mc_y;
    logic [IW-1:0] mc_sel;
    logic          mc_req, busy, frame_done;

    work_dispatcher #(
        .NUM_WORKERS(NW), .WIDTH(W), .HEIGHT(H), .XW(XW), .YW(YW)
    ) dut (
        .clk(clk), .n_rst(n_rst), .frame_start(frame_start),
        .JW_ready(JW_ready), .JW_done(JW_done), .mc_ack(mc_ack),
        .JW_start(JW_start), .pix_x(pix_x), .pix_y(pix_y), .MC_busy(MC_busy),
        .mc_req(mc_req), .mc_sel(mc_sel), .mc_x(mc_x), .mc_y(mc_y),
        .busy(busy), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic        fs;
        logic [3:0]  rdy;
        logic [3:0]  dn;
        logic        ack;
        logic [22:0] exp;
    } vec_t;

    vec_t vecs [11];

    // Raster / round-robin / stall scratch state
    int         ex, ey, issued, writes, fd_cnt, post, ng, dips, last_g;
    int         cmx [NW];
    int         cmy [NW];
    int         cnt [NW];
    bit         comp [NW];
    int         g [3];
    logic [3:0] rdy, jd, lowbits;
    logic       prev_req, prev_dip;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [22:0] pk(input logic [3:0] st, input logic [2:0] px,
                                       input logic [1:0] py, input logic rq,
                                       input logic [1:0] sl, input logic [2:0] mx,
                                       input logic [1:0] my, input logic [3:0] mb,
                                       input logic bz, input logic fd);
        return {st, px, py, rq, sl, mx, my, mb, bz, fd};
    endfunction

    function automatic logic [22:0] outs();
        return pk(JW_start, pix_x, pix_y, mc_req, mc_sel, mc_x, mc_y, MC_busy, busy, frame_done);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        n_rst = 1'b0;
        frame_start = 1'b0;
        JW_ready = '0;
        JW_done = '0;
        mc_ack = 1'b0;
        tick();
        n_rst = 1'b1;
    endtask

    initial begin
        // Worker 0 takes a pixel, ignores a stray done from idle worker 2, waits out
        // a one-cycle ack stall, is released, then a second issue and an rr=1 grant.
        vecs[0]  = '{1'b1, 4'h0, 4'h0, 1'b0, pk(4'h0, 3'd0, 2'd0, 1'b0, 2'd0, 3'd0, 2'd0, 4'hF, 1'b1, 1'b0)};
        vecs[1]  = '{1'b0, 4'h1, 4'h4, 1'b0, pk(4'h1, 3'd0, 2'd0, 1'b0, 2'd0, 3'd0, 2'd0, 4'hF, 1'b1, 1'b0)};
        vecs[2]  = '{1'b0, 4'h1, 4'h4, 1'b0, pk(4'h0, 3'd0, 2'd0, 1'b0, 2'd0, 3'd0, 2'd0, 4'hF, 1'b1, 1'b0)};
        vecs[3]  = '{1'b0, 4'h1, 4'h1, 1'b0, pk(4'h0, 3'd0, 2'd0, 1'b1, 2'd0, 3'd0, 2'd0, 4'hF, 1'b1, 1'b0)};
        vecs[4]  = '{1'b0, 4'h1, 4'h1, 1'b0, pk(4'h0, 3'd0, 2'd0, 1'b1, 2'd0, 3'd0, 2'd0, 4'hF, 1'b1, 1'b0)};
        vecs[5]  = '{1'b0, 4'h1, 4'h1, 1'b1, pk(4'h0, 3'd0, 2'd0, 1'b0, 2'd0, 3'd0, 2'd0, 4'hE, 1'b1, 1'b0)};
        vecs[6]  = '{1'b0, 4'h1, 4'h0, 1'b0, pk(4'h0, 3'd0, 2'd0, 1'b0, 2'd0, 3'd0, 2'd0, 4'hF, 1'b1, 1'b0)};
        vecs[7]  = '{1'b0, 4'h1, 4'h0, 1'b0, pk(4'h1, 3'd1, 2'd0, 1'b0, 2'd0, 3'd0, 2'd0, 4'hF, 1'b1, 1'b0)};
        vecs[8]  = '{1'b0, 4'h2, 4'h0, 1'b0, pk(4'h2, 3'd2, 2'd0, 1'b0, 2'd0, 3'd0, 2'd0, 4'hF, 1'b1, 1'b0)};
        vecs[9]  = '{1'b0, 4'h0, 4'h3, 1'b0, pk(4'h0, 3'd2, 2'd0, 1'b1, 2'd1, 3'd2, 2'd0, 4'hF, 1'b1, 1'b0)};
        vecs[10] = '{1'b0, 4'h0, 4'h3, 1'b0, pk(4'h0, 3'd2, 2'd0, 1'b1, 2'd1, 3'd2, 2'd0, 4'hF, 1'b1, 1'b0)};

        // Reset with random inputs
        n_rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            frame_start = 1'($urandom);
            JW_ready    = 4'($urandom);
            JW_done     = 4'($urandom);
            mc_ack      = 1'($urandom);
            tick();
        end
        check("reset outputs", 32'(outs()),
              32'(pk(4'h0, 3'd0, 2'd0, 1'b0, 2'd0, 3'd0, 2'd0, 4'hF, 1'b0, 1'b0)));

        n_rst = 1'b1;
        for (int i = 0; i < 11; i++) begin
            frame_start = vecs[i].fs;
            JW_ready    = vecs[i].rdy;
            JW_done     = vecs[i].dn;
            mc_ack      = vecs[i].ack;
            tick();
            check($sformatf("vec%0d", i), 32'(outs()), 32'(vecs[i].exp));
        end

        // Mid-frame reset while in W_REQ, then restart from (0,0)
        n_rst = 1'b0;
        tick();
        check("midreset outputs", 32'(outs()),
              32'(pk(4'h0, 3'd0, 2'd0, 1'b0, 2'd0, 3'd0, 2'd0, 4'hF, 1'b0, 1'b0)));
        n_rst = 1'b1;
        JW_done = '0;
        mc_ack = 1'b0;
        frame_start = 1'b1;
        JW_ready = 4'h1;
        tick();
        frame_start = 1'b0;
        tick();
        check("restart first issue", 32'({JW_start, pix_x, pix_y}), 32'({4'h1, 3'd0, 2'd0}));

        // Raster order with workers 0 and 1 modelled, immediate ack
        reset_dut();
        ex = 0; ey = 0; issued = 0; writes = 0; fd_cnt = 0; post = 0;
        prev_req = 1'b0;
        rdy = 4'b0011;
        jd = '0;
        for (int w = 0; w < NW; w++) begin
            comp[w] = 1'b0;
            cnt[w] = 0;
            cmx[w] = 0;
            cmy[w] = 0;
        end
        JW_ready = rdy;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        for (int c = 0; c < 300; c++) begin
            if (frame_done) fd_cnt++;
            for (int w = 0; w < NW; w++) begin
                if (comp[w]) begin
                    if (cnt[w] == 0) begin
                        comp[w] = 1'b0;
                        jd[w] = 1'b1;
                    end else begin
                        cnt[w]--;
                    end
                end
            end
            if (JW_start != '0) begin
                check("raster issue x", 32'(pix_x), ex);
                check("raster issue y", 32'(pix_y), ey);
                check("raster issue onehot", 32'($onehot(JW_start) && JW_start[3:2] == 2'b00), 1);
                for (int w = 0; w < NW; w++) begin
                    if (JW_start[w]) begin
                        cmx[w] = ex;
                        cmy[w] = ey;
                        rdy[w] = 1'b0;
                        comp[w] = 1'b1;
                        cnt[w] = w + 1;
                    end
                end
                issued++;
                ex++;
                if (ex == W) begin
                    ex = 0;
                    ey++;
                end
            end
            if (mc_req && !prev_req) begin
                check("raster write x", 32'(mc_x), cmx[mc_sel]);
                check("raster write y", 32'(mc_y), cmy[mc_sel]);
                writes++;
            end
            prev_req = mc_req;
            for (int w = 0; w < NW; w++) begin
                if (!MC_busy[w] && jd[w]) begin
                    jd[w] = 1'b0;
                    rdy[w] = 1'b1;
                end
            end
            JW_ready = rdy;
            JW_done = jd;
            mc_ack = mc_req;
            if (fd_cnt > 0) post++;
            if (post == 6) break;
            tick();
        end
        check("raster issued count", issued, 8);
        check("raster write count", writes, 8);
        check("raster frame_done pulses", fd_cnt, 1);
        check("raster busy after frame", 32'(busy), 0);

        // Round-robin: workers 0, 1, 3 done together, rr=0
        reset_dut();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        JW_ready = 4'b1011;
        tick();
        check("rr issue w0", 32'(JW_start), 32'h1);
        tick();
        check("rr issue w1", 32'(JW_start), 32'h2);
        tick();
        check("rr issue w3", 32'(JW_start), 32'h8);
        JW_ready = '0;
        JW_done = 4'b1011;
        mc_ack = 1'b1;
        prev_req = 1'b0;
        prev_dip = 1'b0;
        ng = 0; dips = 0; last_g = 0;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (mc_req && !prev_req) begin
                if (ng < 3) g[ng] = int'(mc_sel);
                ng++;
                last_g = int'(mc_sel);
            end
            prev_req = mc_req;
            if (MC_busy != 4'hF) begin
                dips++;
                lowbits = ~MC_busy;
                check("rr dip bit", 32'(lowbits), 32'(1) << last_g);
                check("rr dip width", 32'(prev_dip), 0);
                prev_dip = 1'b1;
                JW_done = JW_done & MC_busy;
            end else begin
                prev_dip = 1'b0;
            end
        end
        check("rr grant count", ng, 3);
        check("rr grant order", {g[0][7:0], g[1][7:0], g[2][7:0]}, {8'd0, 8'd1, 8'd3});
        check("rr dip count", dips, 3);
        mc_ack = 1'b0;
        JW_done = '0;

        // Ack stall: worker 2 holds (1,0), ack held low 5 cycles
        reset_dut();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        JW_ready = 4'b0001;
        tick();
        JW_ready = 4'b0100;
        tick();
        JW_ready = '0;
        JW_done = 4'b0100;
        for (int i = 0; i < 10 && !mc_req; i++) tick();
        check("stall req fields", 32'({mc_req, mc_sel, mc_x, mc_y}), 32'({1'b1, 2'd2, 3'd1, 2'd0}));
        for (int i = 0; i < 5; i++) begin
            tick();
            check("stall hold", 32'({mc_req, mc_sel, mc_x, mc_y, MC_busy}),
                  32'({1'b1, 2'd2, 3'd1, 2'd0, 4'hF}));
        end
        mc_ack = 1'b1;
        tick();
        mc_ack = 1'b0;
        check("stall release", 32'({mc_req, MC_busy}), 32'({1'b0, 4'hB}));
        tick();
        JW_done = '0;
        check("stall rebusy", 32'({mc_req, MC_busy}), 32'({1'b0, 4'hF}));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
